// File: rtl/z_fetch.sv
// z_fetch: instruction-fetch front end for the single-cycle controller.
// Owns the PC, issues one imem read at a time, holds inst until accepted.
module z_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  output logic [31:0] retired,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t state;
  logic   accept;

  assign imem_req  = rst_n & (state == FETCH);
  assign imem_addr = pc;
  assign accept    = inst_valid & inst_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst       <= 32'h0;
      inst_valid <= 1'b0;
      retired    <= 32'h0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            retired    <= retired + 32'd1;
            inst_valid <= 1'b0;
            if (inst == HALT_INST) begin
              state  <= HALT;
              halted <= 1'b1;
            end else if (next_pc[1:0] != 2'b00) begin
              // keep the offending target visible on pc
              state <= FAULT;
              fault <= 1'b1;
              pc    <= next_pc;
            end else begin
              pc    <= next_pc;
              state <= FETCH;
            end
          end
        end
        HALT, FAULT: begin
          inst_valid <= 1'b0;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
